wb_dma_wb_slv_if: RTL

//  WISHBONE slave port of the DMA core; the responder counterpart of the DMA WISHBONE master.

---
 rtl/wb_dma_wb_slv_if.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wb_dma_wb_slv_if.sv
// rtl/wb_dma_wb_slv_if.sv - DMA WISHBONE slave port: register-file decode or master pass-through.
// Optional pass-through watchdog enabled by defining WB_DMA_SLV_PT_TIMEOUT_EN.
module wb_dma_wb_slv_if #(
    parameter logic [3:0] RF_ADDR = 4'h0,
    parameter logic [7:0] PT_TO   = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_addr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    input  logic        pt_en_i,
    output logic [7:0]  slv_adr,
    output logic [31:0] slv_din,
    input  logic [31:0] slv_dout,
    output logic        slv_re,
    output logic        slv_we,
    output logic        pt_sel,
    output logic [70:0] slv_pt_out,
    input  logic [34:0] slv_pt_in
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RF_STB = 3'd1,
        RF_ACK = 3'd2,
        ERR    = 3'd3,
        PT     = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  adr_q, adr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;

    logic        req, rf_hit, rf_ok;
    logic [31:0] pt_data;
    logic        pt_ack, pt_err, pt_rty, pt_resp;
    logic        pt_timeout;

    assign req     = wb_cyc_i & wb_stb_i;
    assign rf_hit  = (wb_addr_i[31:28] == RF_ADDR);
    assign rf_ok   = (wb_sel_i == 4'hf) | ~wb_we_i;
    assign {pt_data, pt_ack, pt_err, pt_rty} = slv_pt_in;
    assign pt_resp = pt_ack | pt_err | pt_rty;

`ifdef WB_DMA_SLV_PT_TIMEOUT_EN
    // Counter sits at zero outside PT, so it is already clear on entry.
    logic [7:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = 8'd0;
        if (state_q == PT) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= 8'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign pt_timeout = (state_q == PT) & (to_cnt_q == PT_TO - 8'd1);
`else
    logic [7:0] pt_to_unused;
    assign pt_to_unused = PT_TO;
    assign pt_timeout   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        din_d   = din_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (rf_hit && rf_ok) begin
                        state_d = RF_STB;
                        adr_d   = wb_addr_i[9:2];
                        din_d   = wb_data_i;
                        we_d    = wb_we_i;
                    end else if (rf_hit) begin
                        state_d = ERR;
                    end else if (pt_en_i) begin
                        state_d = PT;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            RF_STB: begin
                rdata_d = slv_dout;
                state_d = wb_cyc_i ? RF_ACK : IDLE;
            end
            RF_ACK: state_d = IDLE;
            ERR:    state_d = IDLE;
            PT: begin
                // A response on the timeout edge is forwarded and wins.
                if (!wb_cyc_i || pt_resp) begin
                    state_d = IDLE;
                end else if (pt_timeout) begin
                    state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= 8'd0;
            din_q   <= 32'd0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
        end
    end

    assign pt_sel     = (state_q == PT);
    assign slv_re     = (state_q == RF_STB) & ~we_q;
    assign slv_we     = (state_q == RF_STB) & we_q;
    assign slv_adr    = adr_q;
    assign slv_din    = din_q;
    assign slv_pt_out = {wb_data_i, wb_addr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i};

    // Master responses are prioritised so at most one strobe ever reaches the bus.
    assign wb_ack_o  = pt_sel ? (pt_ack & wb_cyc_i)
                              : ((state_q == RF_ACK) & wb_cyc_i);
    assign wb_err_o  = pt_sel ? (pt_err & ~pt_ack & wb_cyc_i)
                              : (state_q == ERR);
    assign wb_rty_o  = pt_sel & pt_rty & ~pt_ack & ~pt_err & wb_cyc_i;
    assign wb_data_o = pt_sel ? pt_data : rdata_q;

endmodule
